// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch, prefetch FIFO and IF/ID register
// DELAY_SLOT_EN keeps the oldest fetched instruction after a taken branch (MIPS delay slot).
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc,
   output logic [31:0] IR_Out,
   output logic [31:0] PC4_Out,
   output logic        id_valid
);
   localparam int unsigned PW = $clog2(BUF_DEPTH);
   localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DROP} state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   req_addr_q, req_addr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   ir_q, ir_d, pc4_q, pc4_d;
   logic          valid_q, valid_d;
   logic [31:0]   ir_mem_q  [BUF_DEPTH];
   logic [31:0]   pc4_mem_q [BUF_DEPTH];
   logic          fifo_empty, has_space, rsp_accept, push, pop;

   assign fifo_empty = (count_q == '0);
   assign has_space  = (count_q < CW'(BUF_DEPTH));
   // Only a response to the live request in S_WAIT carries a usable instruction.
   assign rsp_accept = (state_q == S_WAIT) && imem_rvalid;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      ir_d       = ir_q;
      pc4_d      = pc4_q;
      valid_d    = valid_q;
      imem_req   = 1'b0;
      imem_addr  = '0;
      push       = 1'b0;
      pop        = 1'b0;

      case (state_q)
         S_IDLE:  state_d = S_ISSUE;
         S_ISSUE: begin
            if (!redirect_in && has_space) begin
               imem_req   = 1'b1;
               imem_addr  = pc_q;
               req_addr_d = pc_q;
               pc_d       = pc_q + 32'd4;
               state_d    = S_WAIT;
            end
         end
         S_WAIT:  if (imem_rvalid) state_d = S_ISSUE;
         S_DROP:  if (imem_rvalid) state_d = S_ISSUE;
         default: state_d = S_IDLE;
      endcase

      if (!stall_in) begin
         if (!fifo_empty) begin
            pop     = 1'b1;
            ir_d    = ir_mem_q[rd_ptr_q];
            pc4_d   = pc4_mem_q[rd_ptr_q];
            valid_d = 1'b1;
         end else if (rsp_accept) begin
            ir_d    = imem_rdata;
            pc4_d   = req_addr_q + 32'd4;
            valid_d = 1'b1;
         end else begin
            ir_d    = '0;
            valid_d = 1'b0;
         end
      end
      push = rsp_accept && !(fifo_empty && !stall_in);

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (redirect_in) begin
         pc_d = redirect_pc & 32'hFFFF_FFFC;
`ifdef DELAY_SLOT_EN
         // Head is the delay slot: keep it, everything younger (queue tail, response, in-flight) goes.
         if (!fifo_empty) begin
            push     = 1'b0;
            wr_ptr_d = rd_ptr_q + PW'(1);
            rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
            count_d  = pop ? '0 : CW'(1);
            if ((state_q == S_WAIT) && !imem_rvalid) state_d = S_DROP;
         end
`else
         push     = 1'b0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         if (!stall_in) begin
            ir_d    = '0;
            pc4_d   = pc4_q;
            valid_d = 1'b0;
         end
         if ((state_q == S_WAIT) && !imem_rvalid) state_d = S_DROP;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         ir_q       <= '0;
         pc4_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         ir_q       <= ir_d;
         pc4_q      <= pc4_d;
         valid_q    <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ir_mem_q[wr_ptr_q]  <= imem_rdata;
         pc4_mem_q[wr_ptr_q] <= req_addr_q + 32'd4;
      end
   end

   assign IR_Out   = ir_q;
   assign PC4_Out  = pc4_q;
   assign id_valid = valid_q;
endmodule
